// File: rtl/taxi_eth_tx_sched_pkg.sv
// Shared types and helpers for the frame-level TX scheduler.
package taxi_eth_tx_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  function automatic int idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/taxi_rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr_i, wrapping.
module taxi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // k = N lands back on ptr_i itself, so the last owner is considered last.
    for (int k = 1; k <= N; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        vld_o = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/taxi_eth_tx_frame_sched.sv
// Whole-frame round-robin share of one MAC TX stream, with per-port credit
// limiting and completion routing back to the source port.
module taxi_eth_tx_frame_sched
  import taxi_eth_tx_sched_pkg::*;
#(
  parameter  int PORTS   = 4,
  parameter  int DATA_W  = 8,
  parameter  int TAG_W   = 8,
  parameter  int CPL_W   = 96,
  parameter  int CPL_MAX = 8,
  localparam int IDX_W   = idx_w(PORTS),
  localparam int ID_W    = TAG_W + IDX_W
) (
  input  logic                     logic_clk,
  input  logic                     logic_rst_n,
  input  logic [PORTS*DATA_W-1:0]  s_tx_tdata,
  input  logic [PORTS-1:0]         s_tx_tvalid,
  output logic [PORTS-1:0]         s_tx_tready,
  input  logic [PORTS-1:0]         s_tx_tlast,
  input  logic [PORTS-1:0]         s_tx_tuser,
  input  logic [PORTS*TAG_W-1:0]   s_tx_tid,
  output logic [DATA_W-1:0]        m_tx_tdata,
  output logic                     m_tx_tvalid,
  input  logic                     m_tx_tready,
  output logic                     m_tx_tlast,
  output logic                     m_tx_tuser,
  output logic [ID_W-1:0]          m_tx_tid,
  input  logic [CPL_W-1:0]         s_cpl_tdata,
  input  logic [ID_W-1:0]          s_cpl_tid,
  input  logic                     s_cpl_tvalid,
  output logic                     s_cpl_tready,
  output logic [CPL_W-1:0]         m_cpl_tdata,
  output logic [TAG_W-1:0]         m_cpl_tid,
  output logic [PORTS-1:0]         m_cpl_tvalid,
  input  logic [PORTS-1:0]         m_cpl_tready,
  input  logic [PORTS-1:0]         cfg_port_en,
  output logic [PORTS-1:0]         stat_grant,
  output logic                     stat_busy,
  output logic                     stat_cpl_err
);

  localparam int CNT_W = $clog2(CPL_MAX + 1);

  state_t                        state_q;
  logic [IDX_W-1:0]              grant_q, ptr_q;
  logic [PORTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                          err_q, err_d;

  logic [PORTS-1:0]  req, pick_gnt, cpl_sel, inc, dec;
  logic [IDX_W-1:0]  pick_idx, cpl_idx;
  logic              pick_vld, pass, beat_end, idx_ok, cpl_hs;

  always_comb begin
    for (int i = 0; i < PORTS; i++)
      req[i] = s_tx_tvalid[i] & cfg_port_en[i] & (cnt_q[i] < CNT_W'(CPL_MAX));
  end

  taxi_rr_pick #(.N(PORTS), .IW(IDX_W)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign pass = (state_q == PASS);

  always_comb begin
    m_tx_tdata  = '0;
    m_tx_tvalid = 1'b0;
    m_tx_tlast  = 1'b0;
    m_tx_tuser  = 1'b0;
    m_tx_tid    = '0;
    s_tx_tready = '0;
    stat_grant  = '0;
    if (pass) begin
      m_tx_tdata  = s_tx_tdata[int'(grant_q)*DATA_W +: DATA_W];
      m_tx_tvalid = s_tx_tvalid[grant_q];
      m_tx_tlast  = s_tx_tlast[grant_q];
      m_tx_tuser  = s_tx_tuser[grant_q];
      m_tx_tid    = {grant_q, s_tx_tid[int'(grant_q)*TAG_W +: TAG_W]};
      s_tx_tready[grant_q] = m_tx_tready;
      stat_grant[grant_q]  = 1'b1;
    end
  end

  assign beat_end  = m_tx_tvalid & m_tx_tready & m_tx_tlast;
  assign stat_busy = pass;

  // Completions with an out-of-range port index are swallowed, never stalled.
  assign cpl_idx     = s_cpl_tid[ID_W-1 -: IDX_W];
  assign idx_ok      = int'(cpl_idx) < PORTS;
  assign m_cpl_tdata = s_cpl_tdata;
  assign m_cpl_tid   = s_cpl_tid[TAG_W-1:0];

  always_comb begin
    m_cpl_tvalid = '0;
    cpl_sel      = '0;
    s_cpl_tready = !idx_ok;
    for (int i = 0; i < PORTS; i++) begin
      if (idx_ok && int'(cpl_idx) == i) begin
        cpl_sel[i]      = 1'b1;
        m_cpl_tvalid[i] = s_cpl_tvalid;
        s_cpl_tready    = m_cpl_tready[i];
      end
    end
  end

  assign cpl_hs = s_cpl_tvalid & s_cpl_tready;

  always_comb begin
    inc   = '0;
    dec   = '0;
    cnt_d = cnt_q;
    err_d = cpl_hs & !idx_ok;
    for (int i = 0; i < PORTS; i++) begin
      inc[i] = !pass & pick_gnt[i];
      dec[i] = cpl_hs & cpl_sel[i];
      if (inc[i] && !dec[i])
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec[i] && !inc[i] && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - 1'b1;
      if (dec[i] && cnt_q[i] == '0)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(PORTS - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        IDLE: if (pick_vld) begin
          grant_q <= pick_idx;
          state_q <= PASS;
        end
        PASS: if (beat_end) begin
          ptr_q   <= grant_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stat_cpl_err = err_q;

endmodule

// File: tb/tb_taxi_eth_tx_frame_sched.sv
// Directed + randomized bench for the TX frame scheduler against a rule-level model.
module tb_taxi_eth_tx_frame_sched;

  localparam int P     = 5;
  localparam int DW    = 8;
  localparam int TW    = 8;
  localparam int CW    = 16;
  localparam int CMAX  = 2;
  localparam int IDXW  = $clog2(P);
  localparam int IDW   = TW + IDXW;

  logic              logic_clk = 1'b0;
  logic              logic_rst_n;
  logic [P*DW-1:0]   s_tx_tdata;
  logic [P-1:0]      s_tx_tvalid, s_tx_tready, s_tx_tlast, s_tx_tuser;
  logic [P*TW-1:0]   s_tx_tid;
  logic [DW-1:0]     m_tx_tdata;
  logic              m_tx_tvalid, m_tx_tready, m_tx_tlast, m_tx_tuser;
  logic [IDW-1:0]    m_tx_tid;
  logic [CW-1:0]     s_cpl_tdata, m_cpl_tdata;
  logic [IDW-1:0]    s_cpl_tid;
  logic              s_cpl_tvalid, s_cpl_tready;
  logic [TW-1:0]     m_cpl_tid;
  logic [P-1:0]      m_cpl_tvalid, m_cpl_tready, cfg_port_en, stat_grant;
  logic              stat_busy, stat_cpl_err;

  taxi_eth_tx_frame_sched #(
    .PORTS(P), .DATA_W(DW), .TAG_W(TW), .CPL_W(CW), .CPL_MAX(CMAX)
  ) dut (
    .logic_clk(logic_clk), .logic_rst_n(logic_rst_n),
    .s_tx_tdata(s_tx_tdata), .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready),
    .s_tx_tlast(s_tx_tlast), .s_tx_tuser(s_tx_tuser), .s_tx_tid(s_tx_tid),
    .m_tx_tdata(m_tx_tdata), .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
    .m_tx_tlast(m_tx_tlast), .m_tx_tuser(m_tx_tuser), .m_tx_tid(m_tx_tid),
    .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid), .s_cpl_tvalid(s_cpl_tvalid),
    .s_cpl_tready(s_cpl_tready), .m_cpl_tdata(m_cpl_tdata), .m_cpl_tid(m_cpl_tid),
    .m_cpl_tvalid(m_cpl_tvalid), .m_cpl_tready(m_cpl_tready), .cfg_port_en(cfg_port_en),
    .stat_grant(stat_grant), .stat_busy(stat_busy), .stat_cpl_err(stat_cpl_err)
  );

  always #5 logic_clk = ~logic_clk;

  int nvec = 0, nfail = 0;

  // Reference model: who owns the link, where round-robin resumes, credits in use.
  bit m_busy, m_errp, m_inrst;
  int m_own, m_ptr;
  int m_cnt[P];

  // Per-port frame sources.
  int pend[P], beat[P], flen[P], fno[P];
  bit fuser[P];
  logic [TW-1:0] ftag[P];
  bit rand_len = 0;

  int obs_order[$], exp_order[$];
  bit prev_busy = 0;
  int err_seen = 0;

  function automatic logic [DW-1:0] beat_data(input int p, input int f, input int b);
    return DW'(p * 64 + f * 8 + b + 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_nframes"}, 64'(obs_order.size()), 64'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < obs_order.size(); i++)
      chk({tag, "_owner"}, 64'(obs_order[i]), 64'(exp_order[i]));
    obs_order.delete();
  endtask

  task automatic model_reset();
    m_busy = 0; m_errp = 0; m_own = 0; m_ptr = P - 1;
    for (int p = 0; p < P; p++) m_cnt[p] = 0;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < P; p++) begin
      s_tx_tvalid[p]           = pend[p] > 0;
      s_tx_tdata[p*DW +: DW]   = beat_data(p, fno[p], beat[p]);
      s_tx_tlast[p]            = beat[p] == flen[p] - 1;
      s_tx_tuser[p]            = fuser[p];
      s_tx_tid[p*TW +: TW]     = ftag[p];
    end
  endtask

  task automatic add_frames(input int p, input int n, input int len);
    if (pend[p] == 0) begin
      flen[p] = len; beat[p] = 0;
      fuser[p] = 1'($urandom); ftag[p] = TW'($urandom);
    end
    pend[p] += n;
    drive_inputs();
  endtask

  task automatic clear_sources();
    for (int p = 0; p < P; p++) begin pend[p] = 0; beat[p] = 0; end
    drive_inputs();
  endtask

  task automatic advance(input int p);
    if (beat[p] == flen[p] - 1) begin
      beat[p] = 0; fno[p]++; pend[p]--;
      fuser[p] = 1'($urandom); ftag[p] = TW'($urandom);
      if (rand_len) flen[p] = $urandom_range(1, 4);
    end else beat[p]++;
  endtask

  // One clock: compare at the falling edge, advance model, then drive after the rising edge.
  task automatic step();
    logic [P-1:0] exp_rdy, exp_gnt, exp_mcv;
    bit exp_scr, hs, found;
    int idx, j, g, incp, decp;
    @(negedge logic_clk);
    exp_rdy = '0; exp_gnt = '0;
    if (m_busy) begin
      exp_gnt[m_own] = 1'b1;
      if (m_tx_tready) exp_rdy[m_own] = 1'b1;
      chk("tx_valid", 64'(m_tx_tvalid), 64'(pend[m_own] > 0));
      if (pend[m_own] > 0) begin
        chk("tx_data", 64'(m_tx_tdata), 64'(beat_data(m_own, fno[m_own], beat[m_own])));
        chk("tx_last", 64'(m_tx_tlast), 64'(beat[m_own] == flen[m_own] - 1));
        chk("tx_user", 64'(m_tx_tuser), 64'(fuser[m_own]));
        chk("tx_tid", 64'(m_tx_tid), (64'(m_own) << TW) | 64'(ftag[m_own]));
      end
    end else chk("tx_valid_idle", 64'(m_tx_tvalid), 64'd0);
    chk("tx_ready", 64'(s_tx_tready), 64'(exp_rdy));
    chk("stat_grant", 64'(stat_grant), 64'(exp_gnt));
    chk("stat_busy", 64'(stat_busy), 64'(m_busy));
    chk("stat_cpl_err", 64'(stat_cpl_err), 64'(m_errp));
    if (stat_cpl_err === 1'b1) err_seen++;

    idx = int'(s_cpl_tid >> TW);
    exp_mcv = '0; exp_scr = 1'b1;
    if (idx < P) begin exp_mcv[idx] = s_cpl_tvalid; exp_scr = m_cpl_tready[idx]; end
    chk("cpl_tvalid", 64'(m_cpl_tvalid), 64'(exp_mcv));
    if (s_cpl_tvalid) begin
      chk("cpl_tready", 64'(s_cpl_tready), 64'(exp_scr));
      chk("cpl_data", 64'(m_cpl_tdata), 64'(s_cpl_tdata));
      chk("cpl_tag", 64'(m_cpl_tid), 64'(s_cpl_tid[TW-1:0]));
    end

    if (stat_busy === 1'b1 && !prev_busy)
      for (int q = 0; q < P; q++) if (stat_grant[q]) obs_order.push_back(q);
    prev_busy = (stat_busy === 1'b1);

    if (m_inrst) begin
      m_errp = 0;
    end else begin
      hs = s_cpl_tvalid && exp_scr;
      incp = -1; found = 0; g = 0;
      if (!m_busy) begin
        for (int k = 1; k <= P; k++) begin
          j = (m_ptr + k) % P;
          if (!found && pend[j] > 0 && cfg_port_en[j] && m_cnt[j] < CMAX) begin
            found = 1; g = j;
          end
        end
        if (found) begin m_busy = 1; m_own = g; incp = g; end
      end else if (pend[m_own] > 0 && m_tx_tready && beat[m_own] == flen[m_own] - 1) begin
        m_busy = 0; m_ptr = m_own;
      end
      decp = (hs && idx < P) ? idx : -1;
      m_errp = hs && (idx >= P || m_cnt[idx] == 0);
      if (incp >= 0 && incp != decp) m_cnt[incp]++;
      if (decp >= 0 && decp != incp && m_cnt[decp] > 0) m_cnt[decp]--;
    end
    for (int p = 0; p < P; p++) if (exp_rdy[p] && pend[p] > 0) advance(p);
    @(posedge logic_clk); #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    logic_rst_n = 1'b0;
    model_reset(); m_inrst = 1;
    clear_sources();
    step(); step();
    logic_rst_n = 1'b1; m_inrst = 0;
  endtask

  initial begin
    logic_rst_n = 1'b0;
    cfg_port_en = '1; m_tx_tready = 1'b1;
    s_cpl_tvalid = 1'b0; s_cpl_tid = '0; s_cpl_tdata = '0; m_cpl_tready = '0;
    for (int p = 0; p < P; p++) begin
      pend[p] = 0; beat[p] = 0; flen[p] = 1; fno[p] = 0; fuser[p] = 0; ftag[p] = '0;
    end
    model_reset(); m_inrst = 1;
    drive_inputs();
    repeat (3) step();
    logic_rst_n = 1'b1; m_inrst = 0;

    // Two simultaneous 3-beat frames: port 0 first, then port 2.
    add_frames(0, 1, 3); add_frames(2, 1, 3);
    repeat (12) step();
    exp_order = {0, 2}; chk_order("t1");

    // Everyone streams two frames: strict rotation.
    do_reset();
    for (int p = 0; p < P; p++) add_frames(p, 2, 2);
    repeat (40) step();
    exp_order = {0, 1, 2, 3, 4, 0, 1, 2, 3, 4}; chk_order("t2");

    // Credit exhaustion on port 1, freed by one completion.
    do_reset();
    add_frames(1, 3, 2);
    repeat (20) step();
    exp_order = {1, 1}; chk_order("t3_blocked");
    s_cpl_tvalid = 1'b1; s_cpl_tid = {3'd1, 8'h5A}; s_cpl_tdata = CW'($urandom);
    m_cpl_tready = 5'b00010;
    step();
    s_cpl_tvalid = 1'b0; m_cpl_tready = '0;
    repeat (10) step();
    exp_order = {1}; chk_order("t3_released");

    // Back-pressure toggling mid-frame.
    add_frames(3, 1, 6);
    repeat (40) begin m_tx_tready = 1'($urandom_range(0, 1)); step(); end
    m_tx_tready = 1'b1;
    repeat (10) step();
    exp_order = {3}; chk_order("t4");

    // Out-of-range completion index, then completion on a port with no credit in use.
    err_seen = 0;
    s_cpl_tvalid = 1'b1; s_cpl_tid = {3'd5, 8'h33}; s_cpl_tdata = CW'($urandom);
    step();
    s_cpl_tvalid = 1'b0;
    repeat (3) step();
    chk("t5_err_pulses_badidx", 64'(err_seen), 64'd1);
    err_seen = 0;
    s_cpl_tvalid = 1'b1; s_cpl_tid = {3'd4, 8'h77}; m_cpl_tready = 5'b10000;
    step();
    s_cpl_tvalid = 1'b0; m_cpl_tready = '0;
    repeat (3) step();
    chk("t5_err_pulses_nocredit", 64'(err_seen), 64'd1);

    // Async reset in the middle of a frame; port 3 afterwards gets full credit.
    add_frames(2, 1, 8);
    repeat (3) step();
    logic_rst_n = 1'b0;
    model_reset(); m_inrst = 1;
    repeat (2) step();
    clear_sources();
    logic_rst_n = 1'b1; m_inrst = 0;
    obs_order.delete();
    add_frames(3, 2, 2);
    repeat (12) step();
    exp_order = {3, 3}; chk_order("t6");

    // Randomized traffic, enables, back-pressure and completions.
    do_reset();
    rand_len = 1;
    repeat (1500) begin
      for (int p = 0; p < P; p++)
        if (pend[p] == 0 && $urandom_range(0, 3) == 0) add_frames(p, 1, $urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) cfg_port_en[$urandom_range(0, P - 1)] ^= 1'b1;
      m_tx_tready  = ($urandom_range(0, 3) != 0);
      s_cpl_tvalid = ($urandom_range(0, 2) == 0);
      s_cpl_tid    = {($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                      TW'($urandom)};
      s_cpl_tdata  = CW'($urandom);
      m_cpl_tready = P'($urandom);
      step();
    end
    obs_order.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
